// File: rtl/jpeg_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its neighbours
// (sram_control, cpu_with_ethernet, jpeg2000_top). The scheduler binds the
// slave modport; the surrounding system (or a bench) drives the master side.
`timescale 1ns/1ps
interface jpeg_tile_scheduler_if #(
  parameter int unsigned CNT_W = 25
);
  logic             sram_frame_ready;
  logic             jpeg_working;
  logic             one_image_over;
  logic             cpu_flag;
  logic             start_to_jpeg;
  logic [1:0]       start_reason;
  logic             jpeg_rst_n;
  logic [1:0]       sched_state;
  logic [CNT_W-1:0] sram_cycles;
  logic [CNT_W-1:0] jpeg_cycles;
  logic [CNT_W-1:0] cpu_cycles;

  modport master (
    output sram_frame_ready, jpeg_working, one_image_over, cpu_flag,
    input  start_to_jpeg, start_reason, jpeg_rst_n, sched_state,
           sram_cycles, jpeg_cycles, cpu_cycles
  );

  modport slave (
    input  sram_frame_ready, jpeg_working, one_image_over, cpu_flag,
    output start_to_jpeg, start_reason, jpeg_rst_n, sched_state,
           sram_cycles, jpeg_cycles, cpu_cycles
  );
endinterface

// File: rtl/jpeg_tile_scheduler.sv
// Tile scheduler for jpeg2000_top: issues single-cycle start pulses with a
// reason code (1 next tile, 2 first frame, 3 new frame after drain), holds the
// core in reset for RST_HOLD cycles after each image, and optionally keeps
// cycle statistics. Optional feature macro: STAT_COUNTERS_EN.
`timescale 1ns/1ps
module jpeg_tile_scheduler #(
  parameter int unsigned CNT_W    = 25,
  parameter int unsigned RST_HOLD = 4
) (
  input logic                    clk_100,
  input logic                    rst,
  jpeg_tile_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DRAIN = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic       start_q, start_d;
  logic [1:0] reason_q, reason_d;
  logic       jrst_q, jrst_d;
  logic [3:0] hold_q, hold_d;
  logic       sram_pend_q, sram_pend_d;
  logic       cpu_done_q, cpu_done_d;
  logic       cpu_sync1, cpu_sync2, cpu_prev;
  logic       cpu_rise, cpu_fall;

  // Synchronise the CPU GPIO level and keep one extra stage for edge decode
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      cpu_sync1 <= 1'b0;
      cpu_sync2 <= 1'b0;
      cpu_prev  <= 1'b0;
    end else begin
      cpu_sync1 <= bus.cpu_flag;
      cpu_sync2 <= cpu_sync1;
      cpu_prev  <= cpu_sync2;
    end
  end

  assign cpu_rise = cpu_sync2 & ~cpu_prev;
  assign cpu_fall = ~cpu_sync2 & cpu_prev;

  // Scheduler state and registered outputs
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      reason_q    <= 2'd0;
      jrst_q      <= 1'b0;
      hold_q      <= '0;
      sram_pend_q <= 1'b0;
      cpu_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      reason_q    <= reason_d;
      jrst_q      <= jrst_d;
      hold_q      <= hold_d;
      sram_pend_q <= sram_pend_d;
      cpu_done_q  <= cpu_done_d;
    end
  end

  // Next-state, start decision and flag bookkeeping
  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    reason_d    = reason_q;
    jrst_d      = 1'b1;
    hold_d      = hold_q;
    sram_pend_d = sram_pend_q;
    cpu_done_d  = cpu_done_q;

    if (state_q == S_RUN || state_q == S_DRAIN) begin
      if (bus.sram_frame_ready) sram_pend_d = 1'b1;
      if (cpu_fall)             cpu_done_d  = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.sram_frame_ready) begin
          start_d     = 1'b1;
          reason_d    = 2'd2;
          state_d     = S_RUN;
          sram_pend_d = 1'b0;
          cpu_done_d  = 1'b0;
        end
      end
      S_RUN: begin
        // End of image outranks a coincident tile request
        if (bus.one_image_over) begin
          state_d = S_DRAIN;
          hold_d  = 4'(RST_HOLD);
          jrst_d  = 1'b0;
        end else if (cpu_rise && bus.jpeg_working && !start_q) begin
          start_d    = 1'b1;
          reason_d   = 2'd1;
          cpu_done_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (hold_q != 4'd0) begin
          hold_d = hold_q - 4'd1;
          jrst_d = (hold_q == 4'd1);
        end else if ((sram_pend_q || bus.sram_frame_ready) &&
                     (cpu_done_q || cpu_fall)) begin
          // Live pulses count so a flag arriving this cycle is not delayed
          start_d     = 1'b1;
          reason_d    = 2'd3;
          state_d     = S_RUN;
          sram_pend_d = 1'b0;
          cpu_done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.start_to_jpeg = start_q;
  assign bus.start_reason  = reason_q;
  assign bus.jpeg_rst_n    = jrst_q;
  assign bus.sched_state   = state_q;

`ifdef STAT_COUNTERS_EN
  logic [CNT_W-1:0] sram_cnt, jpeg_cnt, cpu_cnt;

  // Per-image SRAM/core cycle counts and drain-time count, all saturating
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      sram_cnt <= '0;
      jpeg_cnt <= '0;
      cpu_cnt  <= '0;
    end else begin
      if (bus.one_image_over) begin
        sram_cnt <= '0;
        jpeg_cnt <= '0;
      end else if (bus.jpeg_working) begin
        if (jpeg_cnt != '1) jpeg_cnt <= jpeg_cnt + CNT_W'(1);
      end else begin
        if (sram_cnt != '1) sram_cnt <= sram_cnt + CNT_W'(1);
      end
      if (start_d) begin
        cpu_cnt <= '0;
      end else if (state_q == S_DRAIN && cpu_cnt != '1) begin
        cpu_cnt <= cpu_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sram_cycles = sram_cnt;
  assign bus.jpeg_cycles = jpeg_cnt;
  assign bus.cpu_cycles  = cpu_cnt;
`else
  assign bus.sram_cycles = {CNT_W{1'b0}};
  assign bus.jpeg_cycles = {CNT_W{1'b0}};
  assign bus.cpu_cycles  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_jpeg_tile_scheduler.sv
// Bench for jpeg_tile_scheduler: directed stimulus pushes expected start
// pulses (cycle, reason) into a scoreboard; a monitor pops and checks them.
`timescale 1ns/1ps
module tb_jpeg_tile_scheduler;

  localparam int unsigned CW = 4;

  logic clk_100;
  logic rst;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  reason;
  } exp_t;

  exp_t sb[$];

  jpeg_tile_scheduler_if #(.CNT_W(CW)) bus_if ();

  jpeg_tile_scheduler #(.CNT_W(CW), .RST_HOLD(4)) dut (
    .clk_100 (clk_100),
    .rst     (rst),
    .bus     (bus_if.slave)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  initial cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

`ifdef STAT_COUNTERS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_start(input int unsigned c, input logic [1:0] r);
    exp_t e;
    e.cyc    = c;
    e.reason = r;
    sb.push_back(e);
  endtask

  // Monitor: every start pulse must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("start_missing_cycle", 32'(cyc), e.cyc);
      end
      if (rst && bus_if.start_to_jpeg) begin
        if (sb.size() == 0) begin
          chk("unexpected_start_cycle", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("start_cycle", 32'(cyc), e.cyc);
          chk("start_reason", 32'(bus_if.start_reason), 32'(e.reason));
          chk("start_rst_n", 32'(bus_if.jpeg_rst_n), 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus_if.sram_frame_ready = 1'b0;
    bus_if.jpeg_working     = 1'b0;
    bus_if.one_image_over   = 1'b0;
    bus_if.cpu_flag         = 1'b0;

    // T1 reset
    ticks(3);
    chk("rst_start", 32'(bus_if.start_to_jpeg), 0);
    chk("rst_reason", 32'(bus_if.start_reason), 0);
    chk("rst_jrst", 32'(bus_if.jpeg_rst_n), 0);
    chk("rst_state", 32'(bus_if.sched_state), 0);
    chk("rst_jcyc", 32'(bus_if.jpeg_cycles), 0);
    chk("rst_scyc", 32'(bus_if.sram_cycles), 0);
    chk("rst_ccyc", 32'(bus_if.cpu_cycles), 0);
    rst = 1'b1;
    tick();
    chk("rel_jrst", 32'(bus_if.jpeg_rst_n), 1);
    chk("rel_state", 32'(bus_if.sched_state), 0);
    bus_if.cpu_flag = 1'b1; ticks(5);
    bus_if.cpu_flag = 1'b0; ticks(5);
    chk("idle_cpu_ignored", 32'(bus_if.sched_state), 0);

    // T2 first frame
    bus_if.sram_frame_ready = 1'b1;
    expect_start(cyc + 1, 2'd2);
    tick();
    bus_if.sram_frame_ready = 1'b0;
    chk("t2_state", 32'(bus_if.sched_state), 1);
    ticks(2);

    // T3 tile start, held level gives no repeat
    bus_if.jpeg_working = 1'b1;
    bus_if.cpu_flag = 1'b1;
    expect_start(cyc + 3, 2'd1);
    ticks(8);
    chk("t3_reason_held", 32'(bus_if.start_reason), 1);
    bus_if.cpu_flag = 1'b0;
    ticks(4);

    // T4 collision: rise and one_image_over in the same cycle
    bus_if.cpu_flag = 1'b1;
    ticks(2);
    bus_if.one_image_over = 1'b1;
    tick();
    bus_if.one_image_over = 1'b0;
    chk("t4_state", 32'(bus_if.sched_state), 2);
    chk("t4_jrst_low0", 32'(bus_if.jpeg_rst_n), 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t4_jrst_low", 32'(bus_if.jpeg_rst_n), 0);
    end
    tick();
    chk("t4_jrst_high", 32'(bus_if.jpeg_rst_n), 1);

    // T5a drain: cpu fall, sram ready 20 cycles later
    bus_if.cpu_flag = 1'b0;
    ticks(20);
    chk("t5_state_drain", 32'(bus_if.sched_state), 2);
    chk("t5_ccyc_sat", 32'(bus_if.cpu_cycles), STATS ? 32'd15 : 32'd0);
    bus_if.sram_frame_ready = 1'b1;
    expect_start(cyc + 1, 2'd3);
    tick();
    bus_if.sram_frame_ready = 1'b0;
    chk("t5_state_run", 32'(bus_if.sched_state), 1);
    chk("t5_ccyc_clr", 32'(bus_if.cpu_cycles), 0);
    ticks(2);

    bus_if.cpu_flag = 1'b1;
    expect_start(cyc + 3, 2'd1);
    ticks(5);

    // T5b drain: sram during hold alone does not start; later cpu fall does
    bus_if.one_image_over = 1'b1;
    tick();
    bus_if.one_image_over = 1'b0;
    bus_if.sram_frame_ready = 1'b1;
    tick();
    bus_if.sram_frame_ready = 1'b0;
    ticks(8);
    chk("t5b_waiting", 32'(bus_if.sched_state), 2);
    bus_if.cpu_flag = 1'b0;
    expect_start(cyc + 3, 2'd3);
    ticks(4);
    chk("t5b_state_run", 32'(bus_if.sched_state), 1);
    ticks(2);

    bus_if.cpu_flag = 1'b1;
    expect_start(cyc + 3, 2'd1);
    ticks(5);

    // T5c drain: both flags during hold, start right after hold expires
    bus_if.one_image_over = 1'b1;
    expect_start(cyc + 6, 2'd3);
    tick();
    bus_if.one_image_over = 1'b0;
    bus_if.cpu_flag = 1'b0;
    bus_if.sram_frame_ready = 1'b1;
    tick();
    bus_if.sram_frame_ready = 1'b0;
    ticks(6);
    chk("t5c_state_run", 32'(bus_if.sched_state), 1);

    // Rise while core idle is ignored
    bus_if.jpeg_working = 1'b0;
    bus_if.cpu_flag = 1'b1;
    ticks(6);
    chk("rise_idle_core", 32'(bus_if.sched_state), 1);

    // T6 statistics
    bus_if.jpeg_working = 1'b1;
    ticks(20);
    chk("t6_jcyc_sat", 32'(bus_if.jpeg_cycles), STATS ? 32'd15 : 32'd0);
    bus_if.one_image_over = 1'b1;
    tick();
    bus_if.one_image_over = 1'b0;
    chk("t6_jcyc_clr", 32'(bus_if.jpeg_cycles), 0);
    chk("t6_scyc_clr", 32'(bus_if.sram_cycles), 0);
    chk("t6_state", 32'(bus_if.sched_state), 2);
    bus_if.jpeg_working = 1'b0;
    tick();
    chk("t6_scyc_inc", 32'(bus_if.sram_cycles), STATS ? 32'd1 : 32'd0);
    chk("t6_jcyc_hold", 32'(bus_if.jpeg_cycles), 0);

    // Reset mid-image returns everything at once
    ticks(2);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus_if.sched_state), 0);
    chk("mid_rst_jrst", 32'(bus_if.jpeg_rst_n), 0);
    chk("mid_rst_start", 32'(bus_if.start_to_jpeg), 0);
    chk("mid_rst_reason", 32'(bus_if.start_reason), 0);
    chk("mid_rst_scyc", 32'(bus_if.sram_cycles), 0);
    tick();
    rst = 1'b1;
    bus_if.jpeg_working = 1'b1;
    bus_if.cpu_flag = 1'b0; ticks(4);
    bus_if.cpu_flag = 1'b1; ticks(4);
    chk("post_rst_idle", 32'(bus_if.sched_state), 0);
    bus_if.sram_frame_ready = 1'b1;
    expect_start(cyc + 1, 2'd2);
    tick();
    bus_if.sram_frame_ready = 1'b0;
    ticks(4);
    chk("post_rst_state", 32'(bus_if.sched_state), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
